// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types for the 2:1 Wishbone arbiter.
// Provides the arbiter FSM state enum and the one-hot grant encodings
// used by grant_o and by the tie-break picker.
package wb_arb_pkg;
    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GNT0,
        ARB_GNT1,
        ARB_DRAIN
    } arb_state_t;
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;
endpackage

// File: rtl/wishbone_if.sv
// wishbone_if: Wishbone classic bus bundle.
// Signals: cyc, stb, we, adr, sel, dat_o (master write data),
//          dat_i (read data to master), ack.
// Modports: master drives the request side, slave drives dat_i/ack.
interface wishbone_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH/8-1:0] sel;
    logic [DATA_WIDTH-1:0]   dat_o;
    logic [DATA_WIDTH-1:0]   dat_i;
    logic                    ack;
    modport master (output cyc, stb, we, adr, sel, dat_o, input dat_i, ack);
    modport slave  (input cyc, stb, we, adr, sel, dat_o, output dat_i, ack);
endinterface

// File: rtl/wb_arb_pick.sv
// wb_arb_pick: combinational grant picker for two requesters.
// Ports: req  [1:0] - active requests (bit0 = m0, bit1 = m1)
//        last [1:0] - one-hot master granted most recently
//        gnt  [1:0] - one-hot pick, 00 when nothing requests
// Macro WB_ARB_ROUND_ROBIN_EN: ties go to the master not granted last;
// otherwise m0 always wins a tie and last is ignored.
module wb_arb_pick
    import wb_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic [1:0] last,
    output logic [1:0] gnt
);
`ifdef WB_ARB_ROUND_ROBIN_EN
    assign gnt = (req == 2'b11) ? ((last == GNT_M0) ? GNT_M1 : GNT_M0) : req;
`else
    logic unused_last;
    assign unused_last = ^last;
    assign gnt = req[0] ? GNT_M0 : req;
`endif
endmodule

// File: rtl/wb_arbiter_2to1.sv
// wb_arbiter_2to1: two-master to one-slave Wishbone classic arbiter.
// Ports: clk_i, rst_ni (async, active-low)
//        m0, m1  - wishbone_if.slave, fetch and data-memory masters
//        s       - wishbone_if.master, toward the SRAM controller
//        grant_o - one-hot current grant (bit0 m0, bit1 m1)
//        busy_o  - high whenever the FSM is not idle
// Macro WB_ARB_ROUND_ROBIN_EN: round-robin tie-break with a last-grant
// register; undefined gives fixed m0 priority.
module wb_arbiter_2to1
    import wb_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    wishbone_if.slave  m0,
    wishbone_if.slave  m1,
    wishbone_if.master s,
    output logic [1:0] grant_o,
    output logic       busy_o
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    arb_state_t state_q, state_d;
    logic       out_q, out_d;
    logic [1:0] req, last, pick;
    logic       g0, g1;

    assign req = {m1.cyc & m1.stb, m0.cyc & m0.stb};

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic [1:0] last_q, last_d;
    assign last = last_q;
`else
    assign last = GNT_M1;
`endif

    wb_arb_pick u_pick (
        .req  (req),
        .last (last),
        .gnt  (pick)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
            out_q   <= 1'b0;
`ifdef WB_ARB_ROUND_ROBIN_EN
            last_q  <= GNT_M1;
`endif
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
`ifdef WB_ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    // An access is outstanding from the edge the slave takes stb until its ack.
    assign out_d = s.ack ? 1'b0 : (s.cyc & s.stb) ? 1'b1 : out_q;

    always_comb begin
        state_d = state_q;
`ifdef WB_ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick != GNT_NONE) begin
                    state_d = pick[0] ? ARB_GNT0 : ARB_GNT1;
`ifdef WB_ARB_ROUND_ROBIN_EN
                    last_d  = pick;
`endif
                end
            end
            // An ack landing in the abort cycle already retires the access.
            ARB_GNT0:  if (!m0.cyc) state_d = (out_q && !s.ack) ? ARB_DRAIN : ARB_IDLE;
            ARB_GNT1:  if (!m1.cyc) state_d = (out_q && !s.ack) ? ARB_DRAIN : ARB_IDLE;
            ARB_DRAIN: if (s.ack) state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    assign g0 = (state_q == ARB_GNT0);
    assign g1 = (state_q == ARB_GNT1);

    assign s.cyc   = g0 ? m0.cyc   : g1 & m1.cyc;
    assign s.stb   = g0 ? m0.stb   : g1 & m1.stb;
    assign s.we    = g0 ? m0.we    : g1 & m1.we;
    assign s.adr   = g0 ? m0.adr   : g1 ? m1.adr   : {ADDR_WIDTH{1'b0}};
    assign s.sel   = g0 ? m0.sel   : g1 ? m1.sel   : {SEL_WIDTH{1'b0}};
    assign s.dat_o = g0 ? m0.dat_o : g1 ? m1.dat_o : {DATA_WIDTH{1'b0}};

    assign m0.ack   = g0 & s.ack;
    assign m1.ack   = g1 & s.ack;
    assign m0.dat_i = g0 ? s.dat_i : {DATA_WIDTH{1'b0}};
    assign m1.dat_i = g1 ? s.dat_i : {DATA_WIDTH{1'b0}};

    assign grant_o = g0 ? GNT_M0 : g1 ? GNT_M1 : GNT_NONE;
    assign busy_o  = (state_q != ARB_IDLE);
endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// tb_wb_arbiter_2to1: self-checking bench for wb_arbiter_2to1.
// A small SRAM model acks 3 edges after first sampling stb and keeps
// going if the master aborts; per-master queues hold expected read data.
module tb_wb_arbiter_2to1;
    logic       clk;
    logic       rst_n;
    logic [1:0] grant_o;
    logic       busy_o;
    int         n_chk;
    int         n_fail;

    wishbone_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) m0_if ();
    wishbone_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) m1_if ();
    wishbone_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) s_if ();

    wb_arbiter_2to1 #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .m0      (m0_if),
        .m1      (m1_if),
        .s       (s_if),
        .grant_o (grant_o),
        .busy_o  (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Slave model
    logic [31:0] mem [16];
    logic        ack_q, busy_s;
    logic [1:0]  cnt;
    logic [31:0] rdat, r_adr, r_dat;
    logic [3:0]  r_sel;
    logic        r_we;

    assign s_if.ack   = ack_q;
    assign s_if.dat_i = rdat;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q  <= 1'b0;
            busy_s <= 1'b0;
            cnt    <= 2'd0;
            rdat   <= 32'h0;
            r_we   <= 1'b0;
            r_adr  <= 32'h0;
            r_sel  <= 4'h0;
            r_dat  <= 32'h0;
            for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 | i;
            mem[4] <= 32'hDEAD_BEEF;
        end else if (ack_q) begin
            ack_q  <= 1'b0;
            busy_s <= 1'b0;
            cnt    <= 2'd0;
        end else if (busy_s || (s_if.cyc && s_if.stb)) begin
            if (!busy_s) begin
                r_we  <= s_if.we;
                r_adr <= s_if.adr;
                r_sel <= s_if.sel;
                r_dat <= s_if.dat_o;
            end
            busy_s <= 1'b1;
            if (cnt == 2'd2) begin
                ack_q <= 1'b1;
                rdat  <= r_we ? 32'h0 : mem[r_adr[5:2]];
                if (r_we)
                    for (int b = 0; b < 4; b++)
                        if (r_sel[b]) mem[r_adr[5:2]][8*b +: 8] <= r_dat[8*b +: 8];
            end else begin
                cnt <= cnt + 2'd1;
            end
        end
    end

    // Scoreboard: expected read data per master
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    always @(negedge clk) begin
        if (rst_n && (m0_if.ack || m1_if.ack)) begin
            chk("ack_onehot", {m1_if.ack, m0_if.ack} == 2'b11, 1'b0);
            if (m0_if.ack) begin
                chk("m0_ack_expected", q0.size() > 0, 1'b1);
                if (q0.size() > 0) chk("m0_rdata", m0_if.dat_i, q0.pop_front());
            end
            if (m1_if.ack) begin
                chk("m1_ack_expected", q1.size() > 0, 1'b1);
                if (q1.size() > 0) chk("m1_rdata", m1_if.dat_i, q1.pop_front());
            end
        end
    end

    task automatic drive(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        if (m == 0) begin
            m0_if.cyc = cyc; m0_if.stb = stb; m0_if.we = we;
            m0_if.adr = adr; m0_if.sel = sel; m0_if.dat_o = dat;
        end else begin
            m1_if.cyc = cyc; m1_if.stb = stb; m1_if.we = we;
            m1_if.adr = adr; m1_if.sel = sel; m1_if.dat_o = dat;
        end
    endtask

    task automatic push(input int m, input logic [31:0] d);
        if (m == 0) q0.push_back(d);
        else q1.push_back(d);
    endtask

    task automatic wait_ack(output int m, input logic keep_cyc);
        m = -1;
        for (int c = 0; c < 40 && m < 0; c++) begin
            @(negedge clk);
            if (m0_if.ack) m = 0;
            else if (m1_if.ack) m = 1;
        end
        if (m < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL ack_timeout: no ack within 40 cycles, required an ack");
        end else begin
            @(posedge clk);
            #1;
            if (m == 0) begin m0_if.stb = 1'b0; m0_if.cyc = keep_cyc; end
            else begin m1_if.stb = 1'b0; m1_if.cyc = keep_cyc; end
        end
    endtask

    typedef struct {
        int          m;
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] wdat;
        logic [31:0] rdat;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int lat = -1;
        @(posedge clk);
        #1;
        drive(v.m, 1'b1, 1'b1, v.we, v.adr, v.sel, v.wdat);
        push(v.m, v.rdat);
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge clk);
            if (c == 1) chk("pre_grant_stb", s_if.stb, 1'b0);
            if (c == 2) begin
                chk("grant", grant_o, (v.m == 0) ? 2'b01 : 2'b10);
                chk("s_stb", s_if.stb, 1'b1);
                chk("s_we", s_if.we, v.we);
                chk("s_adr", s_if.adr, v.adr);
                chk("s_sel", s_if.sel, v.sel);
                chk("s_dat_o", s_if.dat_o, v.wdat);
            end
            if ((v.m == 0) ? m0_if.ack : m1_if.ack) begin
                lat = c - 1;
                chk("other_dat_i", (v.m == 0) ? m1_if.dat_i : m0_if.dat_i, 32'h0);
            end
        end
        chk("ack_latency", lat, 4);
        @(posedge clk);
        #1;
        drive(v.m, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic tie(input int first, input string tag);
        int m;
        @(posedge clk);
        #1;
        drive(0, 1'b1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        drive(1, 1'b1, 1'b1, 1'b0, 32'h3C, 4'hF, 32'h0);
        push(0, 32'hDEAD_BEEF);
        push(1, 32'h1000_000F);
        wait_ack(m, 1'b0);
        chk({tag, "_first"}, m, first);
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_gap"}, grant_o, 2'b00);
        @(negedge clk);
        chk({tag, "_second_gnt"}, grant_o, (first == 0) ? 2'b10 : 2'b01);
        wait_ack(m, 1'b0);
        chk({tag, "_second"}, m, 1 - first);
    endtask

    vec_t vecs[7];

    initial begin
        int m;
        vecs[0] = '{0, 1'b0, 32'h10, 4'hF, 32'h0,         32'hDEAD_BEEF};
        vecs[1] = '{1, 1'b1, 32'h20, 4'hF, 32'hCAFE_F00D, 32'h0};
        vecs[2] = '{1, 1'b0, 32'h20, 4'hF, 32'h0,         32'hCAFE_F00D};
        vecs[3] = '{0, 1'b1, 32'h24, 4'h3, 32'h1234_5678, 32'h0};
        vecs[4] = '{0, 1'b0, 32'h24, 4'hF, 32'h0,         32'h1000_5678};
        vecs[5] = '{1, 1'b0, 32'h3C, 4'hF, 32'h0,         32'h1000_000F};
        vecs[6] = '{0, 1'b0, 32'h14, 4'hF, 32'h0,         32'h1000_0005};
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_s_ctl", {s_if.cyc, s_if.stb, s_if.we}, 3'b000);
        chk("rst_s_adr_sel", {s_if.adr, s_if.sel}, 36'h0);
        chk("rst_s_dat_o", s_if.dat_o, 32'h0);
        chk("rst_m_ack", {m0_if.ack, m1_if.ack}, 2'b00);
        chk("rst_m_dat", {m0_if.dat_i, m1_if.dat_i}, 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Ties: last grant was m1, so both policies start with m0
        tie(0, "tie1");
        run_vec(vecs[6]);
`ifdef WB_ARB_ROUND_ROBIN_EN
        tie(1, "tie2");
`else
        tie(0, "tie2");
`endif

        // Bus lock: m1 write waits while m0 holds cyc across two transfers
        @(posedge clk);
        #1;
        drive(0, 1'b1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        push(0, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        drive(1, 1'b1, 1'b1, 1'b1, 32'h28, 4'b0011, 32'h1234_5678);
        push(1, 32'h0);
        wait_ack(m, 1'b1);
        chk("lock_first", m, 0);
        repeat (3) begin
            @(negedge clk);
            chk("lock_hold_gnt", grant_o, 2'b01);
            chk("lock_no_issue", {s_if.stb, s_if.we}, 2'b00);
        end
        @(posedge clk);
        #1;
        drive(0, 1'b1, 1'b1, 1'b0, 32'h14, 4'hF, 32'h0);
        push(0, 32'h1000_0005);
        wait_ack(m, 1'b0);
        chk("lock_second", m, 0);
        @(negedge clk);
        @(negedge clk);
        chk("lock_gap", grant_o, 2'b00);
        @(negedge clk);
        chk("lock_m1_gnt", grant_o, 2'b10);
        chk("lock_m1_we", {s_if.stb, s_if.we}, 2'b11);
        chk("lock_m1_adr", s_if.adr, 32'h28);
        chk("lock_m1_sel", s_if.sel, 4'b0011);
        chk("lock_m1_dat", s_if.dat_o, 32'h1234_5678);
        wait_ack(m, 1'b0);
        chk("lock_m1_ack", m, 1);

        // Abort: m0 drops cyc after the slave took stb; m1 waits on the drain
        @(posedge clk);
        #1;
        drive(0, 1'b1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        @(posedge clk);
        #1;
        drive(1, 1'b1, 1'b1, 1'b0, 32'h3C, 4'hF, 32'h0);
        push(1, 32'h1000_000F);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("drain_busy", busy_o, 1'b1);
        chk("drain_grant", grant_o, 2'b00);
        chk("drain_s_cyc_stb", {s_if.cyc, s_if.stb}, 2'b00);
        @(negedge clk);
        chk("drain_late_ack", s_if.ack, 1'b1);
        chk("drain_no_fwd", {m0_if.ack, m1_if.ack}, 2'b00);
        @(negedge clk);
        chk("drain_idle", {busy_o, grant_o}, 3'b000);
        @(negedge clk);
        chk("drain_m1_gnt", grant_o, 2'b10);
        wait_ack(m, 1'b0);
        chk("drain_m1_ack", m, 1);

        // Asynchronous reset during ARB_GNT1
        @(posedge clk);
        #1;
        drive(1, 1'b1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre_gnt", grant_o, 2'b10);
        #2;
        rst_n = 1'b0;
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        chk("rst_async_grant", grant_o, 2'b00);
        chk("rst_async_s_cyc", s_if.cyc, 1'b0);
        chk("rst_async_busy", busy_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tie(0, "rst_tie");

        repeat (2) @(negedge clk);
        chk("sb_empty", q0.size() + q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_arbiter_2to1.md
# wb_arbiter_2to1

Two-master to one-slave Wishbone classic arbiter placed directly upstream of the SRAM controller. It lets the instruction-fetch port (m0) and the data-memory port (m1) share one SRAM controller slave. It holds a grant for the whole bus cycle (`cyc`), routes the granted master's request to the slave, and returns `ack` and read data only to that master. If a master abandons a cycle, the arbiter drains the slave's outstanding access so it cannot complete on behalf of the next master.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of `dat_o` and `dat_i`.
- `ADDR_WIDTH`, 32: width of `adr`. `sel` is `DATA_WIDTH/8` bits.

Ports:
- `clk_i`, input, 1: single clock. All state updates on the rising edge.
- `rst_ni`, input, 1: asynchronous, active-low reset.
- `m0`, `wishbone_if.slave`, bus: master 0 (fetch). Signals are `cyc`, `stb`, `we`, `adr`, `sel`, `dat_o` (write data from master), `dat_i` (read data to master) and `ack`.
- `m1`, `wishbone_if.slave`, bus: master 1 (data memory), same signal set.
- `s`, `wishbone_if.master`, bus: toward the SRAM controller.
- `grant_o`, output, 2: one-hot current grant, bit0 for m0 and bit1 for m1. 00 means no grant.
- `busy_o`, output, 1: high when the state is not ARB_IDLE.

## Operation
- States: ARB_IDLE, ARB_GNT0, ARB_GNT1, ARB_DRAIN.
- A request is `mX.cyc & mX.stb`.
- ARB_IDLE:
  - Only one master requesting: move to ARB_GNTX for that master.
  - Both requesting: the picker decides (see Configuration).
  - Nothing requesting: stay in ARB_IDLE.
- ARB_GNTX:
  - `s.cyc/stb/we/adr/sel/dat_o` are driven from mX, combinationally.
  - `mX.ack = s.ack` and `mX.dat_i = s.dat_i`.
  - The other master sees `ack` = 0 and `dat_i` = 0.
  - The grant is held while `mX.cyc` stays high, including multiple transfers with `stb` low between them (bus lock).
- Outstanding flag:
  - Set on an edge where `s.cyc & s.stb & !s.ack`.
  - Cleared on an edge where `s.ack` is high.
- Release from ARB_GNTX when `mX.cyc` is low:
  - Outstanding = 0: go to ARB_IDLE.
  - Outstanding = 1 (abort mid-access): go to ARB_DRAIN.
- ARB_DRAIN:
  - `s.cyc` and `s.stb` are 0; no ack is forwarded to either master.
  - On `s.ack`, clear outstanding and go to ARB_IDLE.
- Outside ARB_GNTX, all `s` outputs are 0.
- Masters must drop `stb` in the cycle after `ack`. The arbiter does not mask a held `stb`.
- Reset: state ARB_IDLE, outstanding 0, last-grant = m1, `grant_o` = 00, `busy_o` = 0, all `s` outputs 0, both masters' `ack` = 0 and `dat_i` = 0.
- Reset asserted mid-access forces the reset values immediately. The slave is reset by the same `rst_ni` domain, so no drain is required.

## Timing
- The grant is registered. A request sampled at edge N drives `s.stb` from cycle N+1.
- `ack` and read data pass through combinationally, with zero added cycles.
- An SRAM read requested at edge N (arbiter idle) returns `ack` to the master 4 cycles later.
- After a release there is at least one ARB_IDLE cycle before the next grant. This matches the slave's done/idle turnaround.
- When both masters request on the same edge, exactly one grant is issued. The loser keeps `stb` high and is granted right after the one-cycle ARB_IDLE gap following the winner's release.

## Configuration
- `WB_ARB_ROUND_ROBIN_EN` defined:
  - On a tie, grant the master not granted last.
  - Last-grant updates on every grant.
  - After reset, the first tie goes to m0.
- Not defined:
  - Fixed priority: m0 always wins a tie.
  - The last-grant register is removed.

## Structure
- `wb_arb_pkg`: the `arb_state_t` enum and the grant encoding constants (`GNT_NONE` = 2'b00, `GNT_M0` = 2'b01, `GNT_M1` = 2'b10).
- One combinational sub-module, `wb_arb_pick`:
  - Inputs: `req[1:0]` and `last[1:0]`.
  - Output: one-hot `gnt[1:0]`.
  - The macro selects round-robin or fixed priority inside it.
- The FSM, the outstanding flag and the bus muxing live in the top module.

## Test plan
- m0 read of 0x0000_0010 with the slave returning 0xDEAD_BEEF → `s.stb` rises 1 cycle after the request; `m0.ack` 4 cycles after the request with `dat_i` = 0xDEAD_BEEF; `m1.ack` stays 0.
- m0 and m1 request on the same edge, repeated twice:
  - With `WB_ARB_ROUND_ROBIN_EN`: grants go m0, m1, m0, m1.
  - Without it: m0 wins both ties.
- m1 write of 0x1234_5678, `sel` = 4'b0011, while m0 holds a locked `cyc` → the write is not issued until `m0.cyc` falls, then 1 idle cycle, then `s.we` = 1 with the same data and `sel`.
- m0 drops `cyc` 1 cycle after the slave sampled `stb` → state ARB_DRAIN; the late `s.ack` reaches neither master; m1's pending request is granted only after the drain and one idle cycle.
- `rst_ni` pulsed low during ARB_GNT1 → `grant_o` = 00 and `s.cyc` = 0 immediately; after release, the first tie goes to m0.
